// File: rtl/request_unit_pkg.sv
// ============================================================================
// Module   : request_unit_pkg
// Purpose  : Shared state encoding for the memory request arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package request_unit_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DREQ_RD = 2'd1,
      DREQ_WR = 2'd2,
      HALTED  = 2'd3
   } req_state_t;

endpackage : request_unit_pkg

`default_nettype wire

// File: rtl/request_unit.sv
// ============================================================================
// Module   : request_unit
// Purpose  : Arbitrates instruction-fetch and data-access enables; halt is sticky.
// Revision : 1.0
// ============================================================================
`default_nettype none

module request_unit
   import request_unit_pkg::*;
(
   input  logic CLK,
   input  logic nRST,
   input  logic halt,
   input  logic r_req,
   input  logic w_req,
   input  logic iHit,
   input  logic dHit,
   output logic iRen,
   output logic dRen,
   output logic dWen
);

   req_state_t r_state;
   req_state_t w_next_state;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RUN: begin
            // Read wins over write when both are (illegally) requested.
            if (halt)               w_next_state = HALTED;
            else if (iHit && r_req) w_next_state = DREQ_RD;
            else if (iHit && w_req) w_next_state = DREQ_WR;
         end
         DREQ_RD, DREQ_WR: begin
            // A latched data access always completes before halting.
            if (dHit) w_next_state = halt ? HALTED : RUN;
         end
         HALTED:  w_next_state = HALTED;
         default: w_next_state = RUN;
      endcase

      iRen = (r_state != HALTED) && !halt;
      dRen = (r_state == DREQ_RD);
      dWen = (r_state == DREQ_WR);
   end

endmodule : request_unit

`default_nettype wire

// File: tb/tb_request_unit.sv
// ============================================================================
// Module   : tb_request_unit
// Purpose  : Directed, scoreboard-checked bench for request_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_request_unit;

   logic CLK;
   logic nRST;
   logic halt;
   logic r_req;
   logic w_req;
   logic iHit;
   logic dHit;
   logic iRen;
   logic dRen;
   logic dWen;

   typedef struct {
      string tag;
      logic  i;
      logic  r;
      logic  w;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_err;

   request_unit dut (
      .CLK  (CLK),
      .nRST (nRST),
      .halt (halt),
      .r_req(r_req),
      .w_req(w_req),
      .iHit (iHit),
      .dHit (dHit),
      .iRen (iRen),
      .dRen (dRen),
      .dWen (dWen)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One cycle: drive inputs after the falling edge, queue the expected
   // outputs for this cycle, then sample and compare before the rising edge.
   task automatic step(input string tag,
                       input logic n, input logic h, input logic rr,
                       input logic ww, input logic ih, input logic dh,
                       input logic ei, input logic er, input logic ew);
      exp_t e;
      exp_t got;
      @(negedge CLK);
      nRST  = n;
      halt  = h;
      r_req = rr;
      w_req = ww;
      iHit  = ih;
      dHit  = dh;
      e.tag = tag;
      e.i   = ei;
      e.r   = er;
      e.w   = ew;
      sb.push_back(e);
      #1;
      n_cmp++;
      assert (sb.size() != 0) else begin
         n_err++;
         $error("FAIL %s scoreboard empty got 0 entries exp 1", tag);
      end
      if (sb.size() != 0) begin
         got = sb.pop_front();
         n_cmp++;
         assert (iRen === got.i) else begin
            n_err++;
            $error("FAIL %s iRen got %b exp %b", got.tag, iRen, got.i);
         end
         n_cmp++;
         assert (dRen === got.r) else begin
            n_err++;
            $error("FAIL %s dRen got %b exp %b", got.tag, dRen, got.r);
         end
         n_cmp++;
         assert (dWen === got.w) else begin
            n_err++;
            $error("FAIL %s dWen got %b exp %b", got.tag, dWen, got.w);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      nRST  = 1'b0;
      halt  = 1'b0;
      r_req = 1'b0;
      w_req = 1'b0;
      iHit  = 1'b0;
      dHit  = 1'b0;
      repeat (2) @(posedge CLK);

      //    tag          nRST halt r   w   iH  dH   iRen dRen dWen
      step("reset",      1, 0, 0, 0, 0, 0,   1, 0, 0);

      step("ld_issue",   1, 0, 1, 0, 1, 0,   1, 0, 0);
      step("ld_wait1",   1, 0, 0, 0, 0, 0,   1, 1, 0);
      step("ld_wait2",   1, 0, 0, 0, 0, 0,   1, 1, 0);
      step("ld_wait3",   1, 0, 0, 0, 0, 0,   1, 1, 0);
      step("ld_dhit",    1, 0, 0, 0, 0, 1,   1, 1, 0);
      step("ld_release", 1, 0, 1, 0, 0, 0,   1, 0, 0);
      step("ld_noretrig",1, 0, 1, 0, 0, 0,   1, 0, 0);

      step("st_issue",   1, 0, 0, 1, 1, 0,   1, 0, 0);
      step("st_pulse",   1, 0, 0, 0, 0, 1,   1, 0, 1);
      step("run_dhit",   1, 0, 0, 0, 0, 1,   1, 0, 0);
      step("run_idle",   1, 0, 0, 0, 0, 0,   1, 0, 0);

      step("both_issue", 1, 0, 1, 1, 1, 0,   1, 0, 0);
      step("both_rd",    1, 0, 0, 0, 0, 0,   1, 1, 0);

      step("hlt_mid",    1, 1, 0, 0, 0, 0,   0, 1, 0);
      step("hlt_ignore", 1, 1, 0, 1, 1, 0,   0, 1, 0);
      step("hlt_dhit",   1, 1, 0, 0, 0, 1,   0, 1, 0);
      step("hlt_sticky", 1, 0, 0, 0, 0, 0,   0, 0, 0);
      step("hlt_noreq",  1, 0, 1, 0, 1, 0,   0, 0, 0);
      step("hlt_still",  1, 0, 0, 0, 0, 0,   0, 0, 0);

      step("rec_rst",    0, 0, 0, 0, 0, 0,   0, 0, 0);
      step("rec_run",    1, 0, 0, 0, 0, 0,   1, 0, 0);
      step("rec_issue",  1, 0, 1, 0, 1, 0,   1, 0, 0);
      step("rec_pulse",  1, 0, 0, 0, 0, 1,   1, 1, 0);
      step("rec_done",   1, 0, 0, 0, 0, 0,   1, 0, 0);

      step("mid_issue",  1, 0, 0, 1, 1, 0,   1, 0, 0);
      step("mid_rst",    0, 0, 0, 0, 0, 0,   1, 0, 1);
      step("mid_clear",  1, 0, 0, 0, 0, 0,   1, 0, 0);

      step("run_halt",   1, 1, 1, 0, 1, 0,   0, 0, 0);
      step("run_halted", 1, 0, 0, 0, 0, 0,   0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_request_unit

`default_nettype wire
